// File: rtl/fft_pkg.sv
// Shared definitions for the FFT working memory: default geometry,
// complex word field layout and the bank-swap FSM state encoding.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 48;
    localparam int unsigned FFT_DEPTH      = 512;

    // Complex words pack the real part in the upper half, imaginary in the lower.
    localparam int unsigned FFT_IM_LSB     = 0;

    function automatic int unsigned fft_re_lsb(input int unsigned width);
        return width / 2;
    endfunction

    typedef enum logic [1:0] {
        SWAP_IDLE  = 2'd0,
        SWAP_DRAIN = 2'd1,
        SWAP_DO    = 2'd2,
        SWAP_WAIT  = 2'd3
    } swap_state_e;

endpackage

// File: rtl/fft_ram_bank.sv
// One DEPTH x DATA_WIDTH true-dual-port bank, read-first on both ports.
// When both ports write the same address, port 0 data is stored.
module fft_ram_bank
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned DEPTH      = FFT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(DEPTH)-1:0]      i_addr0,
    input  logic [DATA_WIDTH-1:0]         i_data0,
    input  logic                          i_wr_en0,
    output logic [DATA_WIDTH-1:0]         o_data0,
    input  logic [$clog2(DEPTH)-1:0]      i_addr1,
    input  logic [DATA_WIDTH-1:0]         i_data1,
    input  logic                          i_wr_en1,
    output logic [DATA_WIDTH-1:0]         o_data1
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  same_addr;

    assign same_addr = (i_addr0 == i_addr1);

    always_ff @(posedge clk) begin
        if (i_wr_en1 && !(i_wr_en0 && same_addr)) begin
            mem[i_addr1] <= i_data1;
        end
        if (i_wr_en0) begin
            mem[i_addr0] <= i_data0;
        end
    end

    // Read registers see the pre-write array contents, giving read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data0 <= '0;
            o_data1 <= '0;
        end else begin
            o_data0 <= mem[i_addr0];
            o_data1 <= mem[i_addr1];
        end
    end

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong FFT working memory: compute ports A/B own bank o_bank_sel, I/O port C
// owns the other bank; swap FSM exchanges them. Optional: FFT_RAM_BYPASS_EN.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = FFT_DATA_WIDTH,
    parameter int unsigned DEPTH        = FFT_DEPTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(DEPTH)-1:0]      i_addr_a,
    input  logic [DATA_WIDTH-1:0]         i_data_a,
    input  logic                          i_wr_en_a,
    output logic [DATA_WIDTH-1:0]         o_data_a,
    input  logic [$clog2(DEPTH)-1:0]      i_addr_b,
    input  logic [DATA_WIDTH-1:0]         i_data_b,
    input  logic                          i_wr_en_b,
    output logic [DATA_WIDTH-1:0]         o_data_b,
    input  logic [$clog2(DEPTH)-1:0]      i_addr_c,
    input  logic [DATA_WIDTH-1:0]         i_data_c,
    input  logic                          i_wr_en_c,
    output logic [DATA_WIDTH-1:0]         o_data_c,
    input  logic                          i_swap_req,
    output logic                          o_swap_ack,
    output logic                          o_bank_sel,
    output logic                          o_collision,
    input  logic                          i_clr_collision
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    swap_state_e           state;
    logic [1:0]            drain_cnt;
    logic                  sel_q;
    logic                  collide_now;
    logic [DATA_WIDTH-1:0] q0 [2];
    logic [DATA_WIDTH-1:0] q1 [2];
    logic [DATA_WIDTH-1:0] rd_a, rd_b, rd_c;
    logic [DATA_WIDTH-1:0] s1_a, s1_b;

    // Port 0 of each bank carries A or C, port 1 carries B when compute owns it.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic                  compute_owns;
        logic [ADDR_WIDTH-1:0] addr0;
        logic [DATA_WIDTH-1:0] data0;
        logic                  we0;
        logic                  we1;

        assign compute_owns = (o_bank_sel == 1'(g));
        assign addr0        = compute_owns ? i_addr_a  : i_addr_c;
        assign data0        = compute_owns ? i_data_a  : i_data_c;
        assign we0          = compute_owns ? i_wr_en_a : i_wr_en_c;
        assign we1          = compute_owns & i_wr_en_b;

        fft_ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_addr0  (addr0),
            .i_data0  (data0),
            .i_wr_en0 (we0),
            .o_data0  (q0[g]),
            .i_addr1  (i_addr_b),
            .i_data1  (i_data_b),
            .i_wr_en1 (we1),
            .o_data1  (q1[g])
        );
    end

    // Output mux follows the mapping in force when the read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= o_bank_sel;
        end
    end

    assign rd_a = sel_q ? q0[1] : q0[0];
    assign rd_b = sel_q ? q1[1] : q1[0];
    assign rd_c = sel_q ? q0[0] : q0[1];

`ifdef FFT_RAM_BYPASS_EN
    logic                  byp_a_q;
    logic                  byp_b_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_a_q    <= i_wr_en_b && (i_addr_a == i_addr_b);
            byp_b_q    <= i_wr_en_a && (i_addr_a == i_addr_b);
            byp_data_q <= i_wr_en_a ? i_data_a : i_data_b;
        end
    end

    assign s1_a = byp_a_q ? byp_data_q : rd_a;
    assign s1_b = byp_b_q ? byp_data_q : rd_b;
`else
    assign s1_a = rd_a;
    assign s1_b = rd_b;
`endif

    if (READ_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o_data_a <= '0;
                o_data_b <= '0;
                o_data_c <= '0;
            end else begin
                o_data_a <= s1_a;
                o_data_b <= s1_b;
                o_data_c <= rd_c;
            end
        end
    end else begin : g_lat1
        assign o_data_a = s1_a;
        assign o_data_b = s1_b;
        assign o_data_c = rd_c;
    end

    assign collide_now = i_wr_en_a & i_wr_en_b & (i_addr_a == i_addr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_collision <= 1'b0;
        end else if (collide_now) begin
            o_collision <= 1'b1;
        end else if (i_clr_collision) begin
            o_collision <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SWAP_IDLE;
            drain_cnt  <= '0;
            o_bank_sel <= 1'b0;
            o_swap_ack <= 1'b0;
        end else begin
            o_swap_ack <= 1'b0;
            case (state)
                SWAP_IDLE: begin
                    if (i_swap_req) begin
                        state     <= SWAP_DRAIN;
                        drain_cnt <= 2'(READ_LATENCY);
                    end
                end
                SWAP_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state      <= SWAP_DO;
                        o_bank_sel <= ~o_bank_sel;
                        o_swap_ack <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                SWAP_DO: begin
                    state <= SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    if (!i_swap_req) begin
                        state <= SWAP_IDLE;
                    end
                end
                default: begin
                    state <= SWAP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
Double-buffered (ping-pong) working memory for the FFT core. It holds two banks of DEPTH complex words. The compute side (ports A/B, butterfly read/write) owns one bank while the I/O side (port C, sample loader / spectrum unloader) owns the other. A swap handshake exchanges ownership at frame boundaries. It generalises the single-bank dual-port working RAM with parametrised depth and width, configurable read latency, write-collision detection and bank-ownership control.

Parameters:
DATA_WIDTH, 48, word width (re/im packed, re in upper half); must be even
DEPTH, 512, words per bank; power of two, 16..4096
READ_LATENCY, 1, read latency in cycles; 1 = registered RAM output, 2 = extra output register
ADDR_WIDTH, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_addr_a  in  ADDR_WIDTH  compute port A address
i_data_a  in  DATA_WIDTH  compute port A write data
i_wr_en_a  in  1  compute port A write enable
o_data_a  out  DATA_WIDTH  compute port A read data
i_addr_b  in  ADDR_WIDTH  compute port B address
i_data_b  in  DATA_WIDTH  compute port B write data
i_wr_en_b  in  1  compute port B write enable
o_data_b  out  DATA_WIDTH  compute port B read data
i_addr_c  in  ADDR_WIDTH  I/O port address
i_data_c  in  DATA_WIDTH  I/O port write data
i_wr_en_c  in  1  I/O port write enable
o_data_c  out  DATA_WIDTH  I/O port read data
i_swap_req  in  1  request bank exchange (level; held until ack)
o_swap_ack  out  1  one-cycle pulse in the cycle ownership flips
o_bank_sel  out  1  bank currently owned by compute side
o_collision  out  1  sticky: A and B wrote the same address in the same cycle
i_clr_collision  in  1  synchronous clear of o_collision

Behaviour:
- Reset (async, rst_n=0): o_data_a/b/c=0, o_swap_ack=0, o_bank_sel=0, o_collision=0, FSM=IDLE. Memory contents are not reset.
- Compute ports A/B address bank o_bank_sel. Port C addresses bank ~o_bank_sel. Ports never cross banks.
- Writes commit on the rising edge with wr_en=1. Every port reads every cycle: data for the address presented at edge N appears on o_data_x after edge N+READ_LATENCY-1+1. Latency is 1 cycle for READ_LATENCY=1 and 2 cycles for READ_LATENCY=2.
- Read of the same address a port writes in the same cycle returns the old data (read-first).
- A/B both write the same address in the same cycle: port A data wins; o_collision set (sticky) on the next edge. If i_clr_collision and a new collision coincide, the set wins.
- A write on one port with a same-address read on the other port in the same cycle returns old data, unless FFT_RAM_BYPASS_EN is defined.
- Swap FSM:
  - IDLE: i_swap_req=1 -> DRAIN, counter loaded with READ_LATENCY.
  - DRAIN: decrement each cycle; at 0 -> SWAP. Reads issued before the swap therefore complete from the old bank.
  - SWAP: toggle o_bank_sel, o_swap_ack=1 for this single cycle -> WAIT.
  - WAIT: stay until i_swap_req=0 -> IDLE. This prevents double swaps from a held request.
- Accesses issued during DRAIN still target the old mapping. Accesses at the SWAP edge and later use the new mapping.
- Reset mid-DRAIN/SWAP: FSM returns to IDLE, bank_sel=0, and no ack is emitted.
- Addresses wrap naturally at DEPTH; there is no out-of-range handling because ADDR_WIDTH exactly covers DEPTH.

Optional Feature:
FFT_RAM_BYPASS_EN:
- Defined: a same-cycle write on A (or B) to the address being read on the other compute port forwards the new write data to that port's output with the normal latency. If both ports write, port A data is forwarded.
- Not defined: old data is returned (pure BRAM behaviour, no extra muxes).
- Port C is never bypassed.

Decomposition:
- Shared package fft_pkg: DATA_WIDTH/DEPTH defaults, complex word field offsets, swap FSM state encoding constants.
- One natural sub-module fft_ram_bank: a single DEPTH x DATA_WIDTH true-dual-port bank with read-first behaviour, instantiated twice. Port muxing, collision detection, bypass and the swap FSM live in the top.

Test Plan:
1. Reset, then write 48'hABCDE1234567 to A@10 in bank 0, then read A@10 -> value appears after READ_LATENCY cycles; o_bank_sel=0.
2. Write 48'h7654321EDCBA to C@20 (bank 1); read A@20 returns bank-0 content; assert swap_req -> one ack pulse after READ_LATENCY+1 cycles, o_bank_sel=1; now read A@20 -> 48'h7654321EDCBA.
3. Same cycle: A writes 48'hFFFFFFFFFFFF @30, B writes 48'h111111111111 @30 -> o_collision=1 next cycle, read @30 = FFFFFFFFFFFF; pulse i_clr_collision -> 0.
4. A writes 48'h123456789ABC @40 while B reads @40 -> B returns old data without FFT_RAM_BYPASS_EN, and 123456789ABC with it.
5. Hold i_swap_req high for 10 cycles -> exactly one o_swap_ack; bank toggles once.
6. Assert rst_n=0 during DRAIN -> no ack, o_bank_sel=0, all outputs 0 immediately (asynchronous); run for READ_LATENCY=1 and 2.
